// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and defaults shared by the bus-side UART and its receiver.
package uart_pkg;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS       = 8;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rxd, centre-samples an 8N1 frame and pulses o_byte_valid
// for one cycle when a frame with a good stop bit completes.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rxd,
    output logic                      o_byte_valid,
    output logic [UART_DATA_BITS-1:0] o_byte
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    rx_state_t     r_state;
    logic          w_rxd_s;

    assign w_rxd_s = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_state      <= R_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
        end else begin
            r_sync       <= {r_sync[0], i_rxd};
            o_byte_valid <= 1'b0;
            case (r_state)
                R_IDLE: if (!w_rxd_s) begin
                    r_state <= R_START;
                    r_cnt   <= '0;
                end
                // A start bit that is high again at its centre was only a glitch.
                R_START: if (r_cnt == HALF) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= w_rxd_s ? R_IDLE : R_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                R_DATA: if (r_cnt == LAST) begin
                    r_cnt  <= '0;
                    r_idx  <= r_idx + 1'b1;
                    o_byte <= {w_rxd_s, o_byte[UART_DATA_BITS-1:1]};
                    if (r_idx == IW'(UART_DATA_BITS - 1)) r_state <= R_STOP;
                end else r_cnt <= r_cnt + 1'b1;
                R_STOP: if (r_cnt == LAST) begin
                    r_cnt        <= '0;
                    o_byte_valid <= w_rxd_s;
                    r_state      <= R_IDLE;
                end else r_cnt <= r_cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/uart_bus_responder.sv
// uart_bus_responder: UART that answers rdn/wrn strobes on the shared Ram1 data bus,
// sourcing tbre/tsre/data_ready and serialising written bytes onto txd.
module uart_bus_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] data_io,
    input  logic        rdn,
    input  logic        wrn,
    output logic        tbre,
    output logic        tsre,
    output logic        data_ready,
    output logic        txd,
    input  logic        rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic                 r_rdn_q;
    logic                 r_wrn_q;
    logic [DATA_BITS-1:0] r_wr_cap;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_buf;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    tx_state_t            r_tx_state;
    logic                 w_rd_rise;
    logic                 w_wr_rise;
    logic                 w_rx_valid;
    logic [DATA_BITS-1:0] w_rx_byte;

    assign w_rd_rise = !r_rdn_q && rdn;
    assign w_wr_rise = !r_wrn_q && wrn;
    assign data_io   = (!rdn && !rst) ? {{(16 - DATA_BITS){1'b0}}, r_rx_buf} : 16'hzzzz;

    uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rxd        (rxd),
        .o_byte_valid (w_rx_valid),
        .o_byte       (w_rx_byte)
    );

    // A completing byte wins over a read-clear landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdn_q    <= 1'b1;
            r_wrn_q    <= 1'b1;
            r_wr_cap   <= '0;
            r_rx_buf   <= '0;
            data_ready <= 1'b0;
        end else begin
            r_rdn_q <= rdn;
            r_wrn_q <= wrn;
            if (!wrn) r_wr_cap <= data_io[DATA_BITS-1:0];
            if (w_rx_valid) begin
                r_rx_buf   <= w_rx_byte;
                data_ready <= 1'b1;
            end else if (w_rd_rise) data_ready <= 1'b0;
        end
    end

    // Commit needs tbre=1 and every reload needs tbre=0, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            tbre       <= 1'b1;
            tsre       <= 1'b1;
            txd        <= 1'b1;
        end else begin
            if (w_wr_rise && tbre) begin
                r_hold <= r_wr_cap;
                tbre   <= 1'b0;
            end
            case (r_tx_state)
                T_IDLE: if (!tbre) begin
                    r_shift    <= r_hold;
                    tbre       <= 1'b1;
                    tsre       <= 1'b0;
                    txd        <= 1'b0;
                    r_cnt      <= '0;
                    r_tx_state <= T_START;
                end
                T_START: if (r_cnt == LAST) begin
                    r_cnt      <= '0;
                    r_idx      <= '0;
                    txd        <= r_shift[0];
                    r_tx_state <= T_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                T_DATA: if (r_cnt == LAST) begin
                    r_cnt <= '0;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(DATA_BITS - 1)) begin
                        txd        <= 1'b1;
                        r_tx_state <= T_STOP;
                    end else begin
                        txd     <= r_shift[1];
                        r_shift <= r_shift >> 1;
                    end
                end else r_cnt <= r_cnt + 1'b1;
                T_STOP: if (r_cnt == LAST) begin
                    r_cnt <= '0;
                    if (!tbre) begin
                        r_shift    <= r_hold;
                        tbre       <= 1'b1;
                        txd        <= 1'b0;
                        r_tx_state <= T_START;
                    end else begin
                        tsre       <= 1'b1;
                        r_tx_state <= T_IDLE;
                    end
                end else r_cnt <= r_cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_responder.sv
// tb_uart_bus_responder: randomized bus/serial stimulus checked against a cycle-arithmetic
// model of holding-register occupancy, frame timing and the receive buffer.
module tb_uart_bus_responder;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdn = 1'b1;
    logic        wrn = 1'b1;
    logic        rxd = 1'b1;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dat = '0;
    wire  [15:0] data_io;
    logic        tbre, tsre, data_ready, txd;

    assign data_io = tb_oe ? tb_dat : 16'hzzzz;

    uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_io    (data_io),
        .rdn        (rdn),
        .wrn        (wrn),
        .tbre       (tbre),
        .tsre       (tsre),
        .data_ready (data_ready),
        .txd        (txd),
        .rxd        (rxd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         s;
        bit         ok;
    } frm_t;

    frm_t       exp_q[$];
    frm_t       got_q[$];
    int         n_chk = 0, n_bad = 0;
    int         pend_n = 0, pend_l = 0, busy_from = 0, busy_to = 0;
    int         tbre_err = 0, tsre_err = 0;
    bit         flag_en = 1'b0;
    logic [7:0] exp_buf = '0;
    bit         exp_dr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holding register is busy from commit N until the load at L; the line is busy for
    // FRAME cycles from each load, and a commit during a frame loads when that frame ends.
    always @(negedge clk) if (flag_en) begin
        if (tbre !== !(cyc >= pend_n && cyc < pend_l)) tbre_err++;
        if (tsre !== !(cyc >= busy_from && cyc < busy_to)) tsre_err++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                frm_t f;
                f.s  = cyc;
                f.ok = 1'b1;
                f.b  = '0;
                for (int i = 1; i < CPB; i++) begin
                    @(negedge clk);
                    if (txd !== 1'b0) f.ok = 1'b0;
                end
                for (int k = 0; k < 8; k++)
                    for (int i = 0; i < CPB; i++) begin
                        @(negedge clk);
                        if (i == 0) f.b[k] = txd;
                        else if (txd !== f.b[k]) f.ok = 1'b0;
                    end
                for (int i = 0; i < CPB; i++) begin
                    @(negedge clk);
                    if (txd !== 1'b1) f.ok = 1'b0;
                end
                got_q.push_back(f);
            end
        end
    end

    task automatic bus_write(input logic [15:0] w);
        int   n, l;
        frm_t f;
        tb_dat = w;
        tb_oe  = 1'b1;
        wrn    = 1'b0;
        tick();
        tb_oe = 1'b0;
        wrn   = 1'b1;
        n     = cyc + 1;
        tick();
        if (n > pend_l) begin
            l      = (n < busy_to) ? busy_to : n + 1;
            pend_n = n;
            pend_l = l;
            if (l != busy_to) busy_from = l;
            busy_to = l + FRAME;
            f.b  = w[7:0];
            f.s  = l;
            f.ok = 1'b1;
            exp_q.push_back(f);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (CPB) tick();
        end
        rxd = stop;
        repeat (CPB) tick();
        rxd = 1'b1;
        if (stop) begin
            exp_buf = b;
            exp_dr  = 1'b1;
        end
    endtask

    task automatic bus_read(input string tag);
        rdn = 1'b0;
        #1;
        chk(tag, data_io, {8'h00, exp_buf});
        tick();
        rdn = 1'b1;
        tick();
        exp_dr = 1'b0;
        chk({tag, "_dr"}, data_ready, exp_dr);
    endtask

    task automatic tx_compare(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_byte"}, got_q[i].b, exp_q[i].b);
            chk({tag, "_start"}, got_q[i].s, exp_q[i].s);
            chk({tag, "_shape"}, got_q[i].ok, 1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("init_txd", txd, 1);
        chk("init_tbre", tbre, 1);
        chk("init_tsre", tsre, 1);
        chk("init_dr", data_ready, 0);
        rst = 1'b0;
        tick();

        send_rx(8'hA5, 1'b1);
        chk("a5_before_centre", data_ready, 0);
        repeat (3) tick();
        chk("a5_dr", data_ready, exp_dr);
        bus_read("a5_rd");

        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (20) tick();
        chk("glitch_dr", data_ready, exp_dr);
        send_rx(8'h3C, 1'b0);
        repeat (4) tick();
        chk("framing_dr", data_ready, exp_dr);
        bus_read("framing_rd");

        send_rx(8'h11, 1'b1);
        repeat (4) tick();
        send_rx(8'h22, 1'b1);
        repeat (4) tick();
        chk("overrun_dr", data_ready, exp_dr);
        bus_read("overrun_rd");
        repeat (4) tick();
        fork
            send_rx(8'h33, 1'b1);
            begin
                repeat (FRAME) tick();
                rdn = 1'b0;
                tick();
                rdn = 1'b1;
                tick();
                chk("coincide_dr", data_ready, 1);
            end
        join
        bus_read("coincide_rd");

        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            bit         stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(b, stop);
            repeat (4) tick();
            chk("rnd_rx_dr", data_ready, exp_dr);
            if ($urandom_range(0, 1) == 1) bus_read("rnd_rx_rd");
        end
        send_rx(8'h5E, 1'b1);
        repeat (4) tick();

        bus_write(16'h005A);
        tick();
        tick();
        chk("mid_frame_txd", txd, 0);
        rst    = 1'b1;
        tb_dat = 16'hBEEF;
        tb_oe  = 1'b1;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_tbre", tbre, 1);
        chk("rst_tsre", tsre, 1);
        chk("rst_dr", data_ready, 0);
        chk("rst_bus_idle", data_io, 16'hBEEF);
        rdn = 1'b0;
        #1;
        chk("rst_bus_rdn", data_io, 16'hBEEF);
        rdn   = 1'b1;
        tb_oe = 1'b0;
        tick();
        rst = 1'b0;
        repeat (FRAME + 10) tick();
        got_q.delete();
        exp_q.delete();
        pend_n    = 0;
        pend_l    = 0;
        busy_from = 0;
        busy_to   = 0;
        exp_buf   = '0;
        exp_dr    = 1'b0;
        bus_read("post_rst_rd");
        flag_en = 1'b1;

        bus_write(16'h1234);
        chk("t2_tbre_low", tbre, 0);
        tick();
        chk("t2_tbre_high", tbre, 1);
        chk("t2_tsre_low", tsre, 0);
        chk("t2_start_bit", txd, 0);
        repeat (FRAME + 5) tick();
        chk("t2_tsre_high", tsre, 1);
        tx_compare("t2");

        bus_write(16'h0055);
        repeat (8) tick();
        bus_write(16'h00AA);
        repeat (3) tick();
        bus_write(16'h0077);
        chk("t3_tbre_full", tbre, 0);
        repeat (2 * FRAME + 10) tick();
        tx_compare("t3");

        for (int i = 0; i < 12; i++) begin
            bus_write(16'($urandom));
            repeat ($urandom_range(0, 45)) tick();
        end
        repeat (2 * FRAME + 10) tick();
        tx_compare("rnd_tx");
        chk("tbre_trace", tbre_err, 0);
        chk("tsre_trace", tsre_err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
